// File: rtl/alpha_layer_mem_pkg.sv
// Shared sizing helpers for the per-layer alpha (LLR) storage of the SCAN decoder.
package alpha_pkg;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned k = 0; k < 32; k++) begin
            if ((32'd1 << k) < v) r = k + 1;
        end
        return r;
    endfunction

    // Number of LLRs held by layer l.
    function automatic int unsigned layer_size(input int unsigned l);
        return 32'd1 << l;
    endfunction

    function automatic int unsigned wr_chunks(input int unsigned l, input int unsigned p);
        return (layer_size(l) <= p) ? 1 : layer_size(l) / p;
    endfunction

    function automatic int unsigned rd_chunks(input int unsigned l, input int unsigned p);
        return ((layer_size(l) / 2) <= p) ? 1 : (layer_size(l) / 2) / p;
    endfunction

    function automatic int unsigned layer_w_bits(input int unsigned n);
        return clog2(clog2(n) + 1);
    endfunction

    function automatic int unsigned chunk_bits(input int unsigned n, input int unsigned p);
        return (clog2(n / p) < 1) ? 1 : clog2(n / p);
    endfunction

    function automatic int unsigned lane_lsb(input int unsigned i, input int unsigned q);
        return i * q;
    endfunction

endpackage

// File: rtl/alpha_layer_mem_if.sv
// Write/read bus of the alpha layer memory; master drives addresses and data.
interface alpha_layer_mem_if
    import alpha_pkg::*;
#(
    parameter int unsigned N = 1024,
    parameter int unsigned P = 128,
    parameter int unsigned Q = 6
);
    localparam int unsigned LW = layer_w_bits(N);
    localparam int unsigned CW = chunk_bits(N, P);

    logic [P*Q-1:0] a_in;
    logic [LW-1:0]  layer_w;
    logic [CW-1:0]  cnta;
    logic           w_en;
    logic [LW-1:0]  layer_r;
    logic [CW-1:0]  cntb;
    logic           r_en;
    logic [P*Q-1:0] a_out_left;
    logic [P*Q-1:0] a_out_right;
    logic           rd_valid;
    logic           addr_err;

    modport master (
        output a_in, layer_w, cnta, w_en, layer_r, cntb, r_en,
        input  a_out_left, a_out_right, rd_valid, addr_err
    );

    modport slave (
        input  a_in, layer_w, cnta, w_en, layer_r, cntb, r_en,
        output a_out_left, a_out_right, rd_valid, addr_err
    );

endinterface

// File: rtl/alpha_layer_mem_bank.sv
// One decoding-tree layer: chunked write port, combinational left/right read
// that already sees this cycle's write.
module alpha_layer_bank
    import alpha_pkg::*;
#(
    parameter int unsigned LSIZE = 2,
    parameter int unsigned P     = 128,
    parameter int unsigned Q     = 6,
    parameter int unsigned CW    = 3
)(
    input  logic           clk,
    input  logic           rst,
    input  logic           i_we,
    input  logic [CW-1:0]  i_wchunk,
    input  logic [P*Q-1:0] i_wdata,
    input  logic [CW-1:0]  i_rchunk,
    output logic [P*Q-1:0] o_left,
    output logic [P*Q-1:0] o_right
);
    localparam int unsigned H  = LSIZE / 2;
    localparam int unsigned AW = clog2(LSIZE);
    localparam int unsigned PW = clog2(P);

    logic [Q-1:0] r_mem  [LSIZE];
    logic [Q-1:0] w_view [LSIZE];
    logic [Q-1:0] w_lane_in [P];
    logic [Q-1:0] w_lane_l  [P];
    logic [Q-1:0] w_lane_r  [P];

    for (genvar g = 0; g < P; g++) begin : g_lane
        assign w_lane_in[g]                 = i_wdata[lane_lsb(g, Q) +: Q];
        assign o_left[lane_lsb(g, Q) +: Q]  = w_lane_l[g];
        assign o_right[lane_lsb(g, Q) +: Q] = w_lane_r[g];
    end

    // The post-write view is both the next storage state and the read source,
    // which gives write-first bypass for free.
    always_comb begin
        w_view = r_mem;
        for (int unsigned e = 0; e < LSIZE; e++) begin
            if (i_we && ((LSIZE <= P) || ((e / P) == 32'(i_wchunk)))) begin
                w_view[AW'(e)] = w_lane_in[PW'(e % P)];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem <= '{default: '0};
        end else begin
            r_mem <= w_view;
        end
    end

    always_comb begin
        int unsigned idx;
        idx      = 0;
        w_lane_l = '{default: '0};
        w_lane_r = '{default: '0};
        for (int unsigned i = 0; i < P; i++) begin
            if (H <= P) begin
                if (i < H) begin
                    w_lane_l[PW'(i)] = w_view[AW'(i)];
                    w_lane_r[PW'(i)] = w_view[AW'(H + i)];
                end
            end else begin
                idx = 32'(i_rchunk) * P + i;
                if ((H + idx) < LSIZE) begin
                    w_lane_l[PW'(i)] = w_view[AW'(idx)];
                    w_lane_r[PW'(i)] = w_view[AW'(H + idx)];
                end
            end
        end
    end

endmodule

// File: rtl/alpha_layer_mem.sv
// Per-layer alpha storage: layer decode, legality check, registered read
// outputs and the sticky address-error flag around one bank per legal layer.
module alpha_layer_mem
    import alpha_pkg::*;
#(
    parameter int unsigned N      = 1024,
    parameter int unsigned P      = 128,
    parameter int unsigned Q      = 6,
    parameter int unsigned TOP_EN = 0
)(
    input  logic             clk,
    input  logic             rst,
    alpha_layer_mem_if.slave bus
);
    localparam int unsigned L    = clog2(N);
    localparam int unsigned TOPL = (TOP_EN != 0) ? L : L - 1;
    localparam int unsigned LW   = layer_w_bits(N);
    localparam int unsigned CW   = chunk_bits(N, P);
    localparam int unsigned BI   = clog2(TOPL + 1);

    logic           w_wr_ok;
    logic           w_rd_ok;
    logic [P*Q-1:0] w_bank_left  [TOPL+1];
    logic [P*Q-1:0] w_bank_right [TOPL+1];
    logic [P*Q-1:0] w_sel_left;
    logic [P*Q-1:0] w_sel_right;

    logic [P*Q-1:0] r_left;
    logic [P*Q-1:0] r_right;
    logic           r_valid;
    logic           r_err;

    always_comb begin
        w_wr_ok = 1'b0;
        w_rd_ok = 1'b0;
        for (int unsigned l = 1; l <= TOPL; l++) begin
            if (32'(bus.layer_w) == l && 32'(bus.cnta) < wr_chunks(l, P)) w_wr_ok = 1'b1;
            if (32'(bus.layer_r) == l && 32'(bus.cntb) < rd_chunks(l, P)) w_rd_ok = 1'b1;
        end
    end

    assign w_bank_left[0]  = '0;
    assign w_bank_right[0] = '0;

    for (genvar l = 1; l <= TOPL; l++) begin : g_layer
        alpha_layer_bank #(
            .LSIZE (layer_size(l)),
            .P     (P),
            .Q     (Q),
            .CW    (CW)
        ) u_bank (
            .clk      (clk),
            .rst      (rst),
            .i_we     (bus.w_en && w_wr_ok && (bus.layer_w == LW'(l))),
            .i_wchunk (bus.cnta),
            .i_wdata  (bus.a_in),
            .i_rchunk (bus.cntb),
            .o_left   (w_bank_left[l]),
            .o_right  (w_bank_right[l])
        );
    end

    always_comb begin
        w_sel_left  = '0;
        w_sel_right = '0;
        for (int unsigned l = 1; l <= TOPL; l++) begin
            if (32'(bus.layer_r) == l) begin
                w_sel_left  = w_bank_left[BI'(l)];
                w_sel_right = w_bank_right[BI'(l)];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_left  <= '0;
            r_right <= '0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_left  <= (bus.r_en && w_rd_ok) ? w_sel_left  : '0;
            r_right <= (bus.r_en && w_rd_ok) ? w_sel_right : '0;
            r_valid <= bus.r_en;
            r_err   <= r_err | (bus.w_en & ~w_wr_ok) | (bus.r_en & ~w_rd_ok);
        end
    end

    assign bus.a_out_left  = r_left;
    assign bus.a_out_right = r_right;
    assign bus.rd_valid    = r_valid;
    assign bus.addr_err    = r_err;

endmodule

// File: tb/tb_alpha_layer_mem.sv
// Directed bench for alpha_layer_mem: one instance without and one with the top layer.
module tb_alpha_layer_mem;
    localparam int unsigned P = 128;
    localparam int unsigned Q = 6;
    localparam int unsigned W = P * Q;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    alpha_layer_mem_if #(.N(1024), .P(128), .Q(6)) bus0 ();
    alpha_layer_mem_if #(.N(1024), .P(128), .Q(6)) bus1 ();

    alpha_layer_mem #(.N(1024), .P(128), .Q(6), .TOP_EN(0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    alpha_layer_mem #(.N(1024), .P(128), .Q(6), .TOP_EN(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    task automatic chkv(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chkl(input string tag, input logic [Q-1:0] obs, input logic [Q-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chkb(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    function automatic logic [Q-1:0] lane(input logic [W-1:0] v, input int i);
        return Q'(v >> (i * Q));
    endfunction

    function automatic logic [W-1:0] put(input logic [W-1:0] v, input int i, input logic [Q-1:0] x);
        return v | (W'(x) << (i * Q));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus0.a_in = '0; bus0.layer_w = '0; bus0.cnta = '0; bus0.w_en = 1'b0;
        bus0.layer_r = '0; bus0.cntb = '0; bus0.r_en = 1'b0;
        bus1.a_in = '0; bus1.layer_w = '0; bus1.cnta = '0; bus1.w_en = 1'b0;
        bus1.layer_r = '0; bus1.cntb = '0; bus1.r_en = 1'b0;
    endtask

    initial begin
        logic [W-1:0] v;
        logic [W-1:0] el;
        logic [W-1:0] er;

        idle();
        tick();
        tick();
        chkv("rst_left",  bus0.a_out_left,  '0);
        chkv("rst_right", bus0.a_out_right, '0);
        chkb("rst_valid", bus0.rd_valid, 1'b0);
        chkb("rst_err",   bus0.addr_err, 1'b0);
        rst = 1'b0;

        // Layer 9, four chunks, lane value (chunk*128+i) mod 64
        for (int c = 0; c < 4; c++) begin
            v = '0;
            for (int i = 0; i < 128; i++) v = put(v, i, 6'((c * 128 + i) % 64));
            bus0.a_in = v; bus0.layer_w = 4'd9; bus0.cnta = 3'(c); bus0.w_en = 1'b1;
            tick();
        end
        bus0.w_en = 1'b0; bus0.r_en = 1'b1; bus0.layer_r = 4'd9; bus0.cntb = 3'd1;
        tick();
        chkl("t1_left0",  lane(bus0.a_out_left, 0),  6'd0);
        chkl("t1_right5", lane(bus0.a_out_right, 5), 6'd5);
        chkb("t1_valid",  bus0.rd_valid, 1'b1);

        // Chunk-distinguishing pattern on layer 9: (chunk*16+i) mod 64
        bus0.r_en = 1'b0;
        for (int c = 0; c < 4; c++) begin
            v = '0;
            for (int i = 0; i < 128; i++) v = put(v, i, 6'((c * 16 + i) % 64));
            bus0.a_in = v; bus0.layer_w = 4'd9; bus0.cnta = 3'(c); bus0.w_en = 1'b1;
            tick();
        end
        bus0.w_en = 1'b0; bus0.r_en = 1'b1; bus0.layer_r = 4'd9; bus0.cntb = 3'd0;
        tick();
        chkl("t1b_c0_left3",  lane(bus0.a_out_left, 3),  6'd3);
        chkl("t1b_c0_right3", lane(bus0.a_out_right, 3), 6'd35);
        bus0.cntb = 3'd1;
        tick();
        chkl("t1b_c1_right5", lane(bus0.a_out_right, 5), 6'd53);
        el = '0;
        for (int i = 0; i < 128; i++) el = put(el, i, 6'((16 + i) % 64));
        chkv("t1b_c1_left", bus0.a_out_left, el);

        // Layer 3: only 8 elements; upper lanes of the read must be zero
        v = '0;
        for (int i = 0; i < 128; i++) v = put(v, i, (i < 8) ? 6'(i + 1) : 6'h3F);
        bus0.r_en = 1'b0; bus0.a_in = v; bus0.layer_w = 4'd3; bus0.cnta = 3'd0; bus0.w_en = 1'b1;
        tick();
        bus0.w_en = 1'b0; bus0.r_en = 1'b1; bus0.layer_r = 4'd3; bus0.cntb = 3'd0;
        tick();
        el = '0; er = '0;
        for (int i = 0; i < 4; i++) begin
            el = put(el, i, 6'(i + 1));
            er = put(er, i, 6'(i + 5));
        end
        chkv("t2_left",  bus0.a_out_left,  el);
        chkv("t2_right", bus0.a_out_right, er);

        // Layer 7 write-first bypass
        v = '0;
        for (int i = 0; i < 128; i++) v = put(v, i, 6'h05);
        bus0.r_en = 1'b0; bus0.a_in = v; bus0.layer_w = 4'd7; bus0.cnta = 3'd0; bus0.w_en = 1'b1;
        tick();
        v = put('0, 0, 6'h1F);
        for (int i = 1; i < 128; i++) v = put(v, i, 6'h0A);
        bus0.a_in = v; bus0.r_en = 1'b1; bus0.layer_r = 4'd7; bus0.cntb = 3'd0;
        tick();
        chkl("t3_bypass_left0",  lane(bus0.a_out_left, 0),  6'h1F);
        chkl("t3_bypass_right0", lane(bus0.a_out_right, 0), 6'h0A);
        bus0.w_en = 1'b0;
        tick();
        chkl("t3_kept_left0", lane(bus0.a_out_left, 0), 6'h1F);
        chkb("t3_err_clear",  bus0.addr_err, 1'b0);

        // Layer 8: legal chunk 0, then out-of-range chunk 2 must be dropped
        v = '0;
        for (int i = 0; i < 128; i++) v = put(v, i, 6'h11);
        bus0.r_en = 1'b0; bus0.a_in = v; bus0.layer_w = 4'd8; bus0.cnta = 3'd0; bus0.w_en = 1'b1;
        tick();
        v = '0;
        for (int i = 0; i < 128; i++) v = put(v, i, 6'h22);
        bus0.a_in = v; bus0.cnta = 3'd2;
        tick();
        chkb("t4_err_set", bus0.addr_err, 1'b1);
        bus0.w_en = 1'b0; bus0.r_en = 1'b1; bus0.layer_r = 4'd8; bus0.cntb = 3'd0;
        tick();
        el = '0;
        for (int i = 0; i < 128; i++) el = put(el, i, 6'h11);
        chkv("t4_mem_left",  bus0.a_out_left,  el);
        chkv("t4_mem_right", bus0.a_out_right, '0);
        chkb("t4_err_sticky", bus0.addr_err, 1'b1);
        bus0.layer_r = 4'd10;
        tick();
        chkv("t4_top_left",  bus0.a_out_left,  '0);
        chkv("t4_top_right", bus0.a_out_right, '0);
        chkb("t4_top_valid", bus0.rd_valid, 1'b1);
        bus0.layer_r = 4'd8;
        tick();
        bus0.r_en = 1'b0;
        tick();
        chkv("t4_idle_left", bus0.a_out_left, '0);
        chkb("t4_idle_valid", bus0.rd_valid, 1'b0);
        chkb("t4_idle_err",   bus0.addr_err, 1'b1);

        // Top layer 10 on the TOP_EN=1 instance: (chunk*8+i) mod 64
        for (int c = 0; c < 8; c++) begin
            v = '0;
            for (int i = 0; i < 128; i++) v = put(v, i, 6'((c * 8 + i) % 64));
            bus1.a_in = v; bus1.layer_w = 4'd10; bus1.cnta = 3'(c); bus1.w_en = 1'b1;
            tick();
        end
        bus1.w_en = 1'b0; bus1.r_en = 1'b1; bus1.layer_r = 4'd10; bus1.cntb = 3'd3;
        tick();
        chkl("t5_left0",  lane(bus1.a_out_left, 0),  6'd24);
        chkl("t5_right0", lane(bus1.a_out_right, 0), 6'd56);
        chkl("t5_right5", lane(bus1.a_out_right, 5), 6'd61);
        chkb("t5_valid",  bus1.rd_valid, 1'b1);
        chkb("t5_err",    bus1.addr_err, 1'b0);
        bus1.r_en = 1'b0;

        // Asynchronous reset in the middle of a read/write burst on layer 9
        v = '0;
        for (int i = 0; i < 128; i++) v = put(v, i, 6'h2A);
        bus0.a_in = v; bus0.layer_w = 4'd9; bus0.cnta = 3'd0; bus0.w_en = 1'b1;
        bus0.r_en = 1'b1; bus0.layer_r = 4'd9; bus0.cntb = 3'd0;
        tick();
        chkl("t6_pre_left0", lane(bus0.a_out_left, 0), 6'h2A);
        chkb("t6_pre_valid", bus0.rd_valid, 1'b1);
        chkb("t6_pre_err",   bus0.addr_err, 1'b1);
        #3 rst = 1'b1;
        #1;
        chkv("t6_async_left",  bus0.a_out_left,  '0);
        chkv("t6_async_right", bus0.a_out_right, '0);
        chkb("t6_async_valid", bus0.rd_valid, 1'b0);
        chkb("t6_async_err",   bus0.addr_err, 1'b0);
        tick();
        bus0.w_en = 1'b0; bus0.r_en = 1'b1; bus0.layer_r = 4'd9; bus0.cntb = 3'd0;
        rst = 1'b0;
        tick();
        chkv("t6_post_left",  bus0.a_out_left,  '0);
        chkv("t6_post_right", bus0.a_out_right, '0);
        chkb("t6_post_valid", bus0.rd_valid, 1'b1);
        chkb("t6_post_err",   bus0.addr_err, 1'b0);

        idle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
